// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states and default geometry.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, READ, LOAD, START, DATA, STOP} tx_state_t;

  localparam int UART_DATA_WIDTH   = 8;
  localparam int UART_FIFO_DEPTH   = 16;
  localparam int UART_CLKS_PER_BIT = 16;
  localparam int UART_PTR_W        = $clog2(UART_FIFO_DEPTH);

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, flags the last cycle of each bit.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             bit_end
);

  assign bit_end = en && (cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= '0;
    else if (clr)    cnt <= '0;
    else if (en)     cnt <= bit_end ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that pulls bytes from the TX FIFO read port and sends 8N1 frames.
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = UART_DATA_WIDTH,
  parameter int DEPTH        = UART_FIFO_DEPTH,
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fifo_empty,
  input  logic [DATA_WIDTH-1:0]    fifo_dout,
  output logic                     can_read,
  output logic [$clog2(DEPTH)-1:0] rd_ptr,
  output logic                     tx,
  output logic                     busy,
  output logic                     tx_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_WIDTH);

  tx_state_t             state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [IDX_W-1:0]      bit_idx;
  logic [CNT_W-1:0]      cnt;
  logic                  bit_end;
  logic                  cnt_en;
  logic                  cnt_clr;

  assign cnt_en  = (state == START) || (state == DATA) || (state == STOP);
  assign cnt_clr = (state == LOAD);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .cnt    (cnt),
    .bit_end(bit_end)
  );

  // Outputs are set on the edge entering the state they belong to, so they stay registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      rd_ptr   <= '0;
      tx       <= 1'b1;
      can_read <= 1'b0;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      can_read <= 1'b0;
      tx_done  <= 1'b0;
      unique case (state)
        IDLE: if (!fifo_empty) begin
          state    <= READ;
          can_read <= 1'b1;
          busy     <= 1'b1;
        end
        READ: begin
          rd_ptr <= rd_ptr + 1'b1;
          state  <= LOAD;
        end
        LOAD: begin
          shreg   <= fifo_dout;
          bit_idx <= '0;
          tx      <= 1'b0;
          state   <= START;
        end
        START: if (bit_end) begin
          tx    <= shreg[0];
          state <= DATA;
        end
        DATA: if (bit_end) begin
          shreg   <= shreg >> 1;
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
            tx    <= 1'b1;
            state <= STOP;
          end else begin
            tx <= shreg[1];
          end
        end
        STOP: begin
          // Raise tx_done one cycle early so the registered pulse lands on the final stop cycle.
          if (cnt == CNT_W'(CLKS_PER_BIT - 2)) tx_done <= 1'b1;
          if (bit_end) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: FIFO memory model, line-level frame decoder, directed + random bytes.
module tb_uart_tx_fifo_drain;

  localparam int DW  = 8;
  localparam int DEP = 16;
  localparam int CPB = 4;
  localparam int FRAME = (DW + 2) * CPB;

  typedef struct {
    logic [DW-1:0] data;
    int            start;
    int            done;
    int            last;
    bit            clean;
  } frame_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout;
  logic          can_read;
  logic [3:0]    rd_ptr;
  logic          tx, busy, tx_done;

  logic [DW-1:0] mem [DEP];
  int            wr_cnt = 0;
  int            rd_cnt;
  logic          glitch_en = 1'b0;
  logic          glitch_val = 1'b0;
  int            cyc = 0;

  frame_t        frames[$];
  logic [DW-1:0] exp_q[$];
  int            ptr_log[$];
  int            cr_cnt = 0, td_cnt = 0, aborts = 0;

  int errors = 0, checks = 0;
  int base, cr_base, c0, idle_bad, ab0;

  uart_tx_fifo_drain #(.DATA_WIDTH(DW), .DEPTH(DEP), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .can_read(can_read), .rd_ptr(rd_ptr), .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign fifo_empty = glitch_en ? glitch_val : (wr_cnt == rd_cnt);

  // FIFO storage: registered read data the cycle after the strobe.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt    <= 0;
      fifo_dout <= '0;
    end else if (can_read) begin
      fifo_dout <= mem[rd_ptr];
      rd_cnt    <= rd_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (can_read === 1'b1) begin
      cr_cnt <= cr_cnt + 1;
      ptr_log.push_back(int'(rd_ptr));
    end
    if (tx_done === 1'b1) td_cnt <= td_cnt + 1;
  end

  // Line decoder: every frame must be CPB samples per bit, steady, with busy high throughout.
  initial begin : monitor
    frame_t f;
    bit abort;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        f.data = 'x; f.start = cyc; f.done = -1; f.last = 0; f.clean = 1'b1;
        abort = 1'b0;
        for (int b = 0; b < DW + 2 && !abort; b++) begin
          for (int k = 0; k < CPB && !abort; k++) begin
            if (b != 0 || k != 0) @(negedge clk);
            if (rst_n !== 1'b1) abort = 1'b1;
            else begin
              if (b >= 1 && b <= DW) begin
                if (k == 0) f.data[b-1] = tx;
                else if (tx !== f.data[b-1]) f.clean = 1'b0;
              end else if (tx !== ((b == 0) ? 1'b0 : 1'b1)) f.clean = 1'b0;
              if (busy !== 1'b1) f.clean = 1'b0;
              if (tx_done === 1'b1) begin
                if (b == DW + 1 && f.done < 0) f.done = cyc;
                else f.clean = 1'b0;
              end
            end
          end
        end
        if (abort) aborts++;
        else begin
          f.last = cyc;
          frames.push_back(f);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    mem[wr_cnt % DEP] = d;
    wr_cnt++;
    exp_q.push_back(d);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    glitch_en = 1'b0;
    wr_cnt = 0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    base = frames.size();
    cr_base = cr_cnt;
    @(posedge clk); #1;
  endtask

  task automatic wait_frames(input int n, input int budget, input string tag);
    int t = 0;
    while (frames.size() < base + n && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk(tag, frames.size() - base, n);
    repeat (6) @(negedge clk);
  endtask

  task automatic chk_frame(input int i, input string tag);
    if (frames.size() > base + i && exp_q.size() > i) begin
      chk({tag, "_data"}, frames[base+i].data, exp_q[i]);
      chk({tag, "_clean"}, frames[base+i].clean, 1);
      chk({tag, "_done"}, frames[base+i].done - frames[base+i].start, FRAME - 1);
    end else begin
      chk({tag, "_present"}, 0, 1);
    end
  endtask

  initial begin : main
    // Reset and idle
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_can_read", can_read, 0);
    chk("rst_rd_ptr", rd_ptr, 0);
    chk("rst_tx_done", tx_done, 0);
    rst_n = 1'b1;
    idle_bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || can_read !== 1'b0 || rd_ptr !== 4'd0) idle_bad++;
    end
    chk("idle_bad_cycles", idle_bad, 0);
    chk("idle_reads", cr_cnt, 0);

    // Single byte 0xA5
    do_reset();
    c0 = cyc;
    push(8'hA5);
    wait_frames(1, 200, "single_count");
    chk_frame(0, "single");
    if (frames.size() > base) chk("single_latency", frames[base].start - c0, 3);
    chk("single_reads", cr_cnt - cr_base, 1);
    chk("single_rd_ptr", rd_ptr, 1);
    chk("single_busy_after", busy, 0);

    // Back-to-back 0x00, 0xFF
    do_reset();
    push(8'h00);
    push(8'hFF);
    wait_frames(2, 300, "b2b_count");
    chk_frame(0, "b2b0");
    chk_frame(1, "b2b1");
    if (frames.size() > base + 1)
      chk("b2b_gap", frames[base+1].start - frames[base].last - 1, 3);
    chk("b2b_reads", cr_cnt - cr_base, 2);
    chk("b2b_rd_ptr", rd_ptr, 2);

    // Wrap-around: 17 bytes through a 16-entry FIFO
    do_reset();
    ptr_log.delete();
    for (int i = 0; i < 17; i++) begin
      int t = 0;
      while (wr_cnt - rd_cnt >= DEP && t < 500) begin
        @(posedge clk); #1;
        t++;
      end
      push(8'h10 + 8'(i));
    end
    wait_frames(17, 2000, "wrap_count");
    for (int i = 0; i < 17; i++) begin
      if (frames.size() > base + i) chk("wrap_data", frames[base+i].data, exp_q[i]);
    end
    if (ptr_log.size() == 17) begin
      chk("wrap_ptr15", ptr_log[15], 15);
      chk("wrap_ptr16", ptr_log[16], 0);
    end else chk("wrap_ptr_log", ptr_log.size(), 17);
    chk("wrap_rd_ptr", rd_ptr, 1);

    // Reset during DATA bit 3 of 0x3C
    do_reset();
    ab0 = aborts;
    c0 = cyc;
    push(8'h3C);
    while (cyc < c0 + 3 + CPB * 4 + 1) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_tx", tx, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_rd_ptr", rd_ptr, 0);
    chk("midrst_can_read", can_read, 0);
    wr_cnt = 0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    base = frames.size();
    cr_base = cr_cnt;
    chk("midrst_aborted", aborts - ab0, 1);
    @(posedge clk); #1;
    c0 = cyc;
    push(8'hC3);
    wait_frames(1, 200, "midrst_count");
    chk_frame(0, "midrst_next");
    if (frames.size() > base) chk("midrst_latency", frames[base].start - c0, 3);
    chk("midrst_reads", cr_cnt - cr_base, 1);
    chk("midrst_rd_ptr_after", rd_ptr, 1);

    // fifo_empty toggling mid-frame is ignored
    do_reset();
    c0 = cyc;
    push(8'h96);
    while (cyc < c0 + 8) @(posedge clk);
    #1 glitch_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      glitch_val = i[0];
      @(posedge clk); #1;
    end
    glitch_en = 1'b0;
    wait_frames(1, 200, "glitch_count");
    repeat (20) @(negedge clk);
    chk("glitch_frames", frames.size() - base, 1);
    chk_frame(0, "glitch");
    chk("glitch_reads", cr_cnt - cr_base, 1);
    chk("glitch_rd_ptr", rd_ptr, 1);

    // Random bytes with random spacing
    do_reset();
    for (int i = 0; i < 8; i++) begin
      push(8'($urandom));
      repeat ($urandom_range(60)) @(posedge clk);
      #1;
    end
    wait_frames(8, 800, "rand_count");
    for (int i = 0; i < 8; i++) chk_frame(i, "rand");
    for (int i = 1; i < 8; i++)
      if (frames.size() > base + i)
        chk("rand_gap_min", (frames[base+i].start - frames[base+i-1].last - 1) >= 3, 1);
    chk("rand_reads", cr_cnt - cr_base, 8);
    chk("rand_rd_ptr", rd_ptr, 8);

    chk("total_tx_done", td_cnt, frames.size());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
